uart_tx_fifo: RTL
=================

# uart_tx_fifo

Parametrised UART transmitter with an on-chip write FIFO, programmable baud divisor, configurable data width, optional even/odd parity and one or two stop bits. It replaces the fixed 4-bit, single-register TX path of the current UART top. It sits between the host-side register/IO interface and the `tx` pin, and raises a completion interrupt when the queue drains.

## Interface
Parameters:
- `DATA_W`, 8: frame data bits, legal range 5..8.
- `FIFO_DEPTH`, 8: FIFO entries, power of two, at least 2.
- `DIV_W`, 16: width of the baud divisor.

Ports:
- `clk`  in  1: single clock; all logic on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `baud_div`  in  DIV_W: bit period is `baud_div+1` clk cycles; 0 is legal (1 cycle per bit).
- `parity_en`  in  1: append a parity bit.
- `parity_odd`  in  1: 1 selects odd parity, 0 selects even.
- `two_stop`  in  1: 1 selects two stop bits.
- `wr_data`  in  DATA_W: byte to queue.
- `wr_valid`  in  1: write request.
- `wr_ready`  out  1: FIFO not full.
- `fifo_count`  out  $clog2(FIFO_DEPTH)+1: occupied entries.
- `ovf`  out  1: sticky flag; set by a write attempted while full.
- `ovf_clr`  in  1: clears `ovf`.
- `tx`  out  1: serial line, idle high.
- `busy`  out  1: high while a frame is in progress.
- `done_irq`  out  1: one-cycle pulse.

## Operation
- Write: accepted on an edge where `wr_valid && wr_ready`. A write with `wr_valid && !wr_ready` is dropped and sets `ovf`. If `ovf_clr` and an overflow occur in the same cycle, `ovf` ends up set.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: `tx`=1 and `busy`=0. If the FIFO is non-empty, pop the head into the shift register and go to START.
  - At pop, latch `baud_div`, `parity_en`, `parity_odd` and `two_stop`. Config changes mid-frame have no effect on that frame.
  - START: `tx`=0 for one bit period.
  - DATA: send `DATA_W` bits, LSB first.
  - PARITY: entered only if the latched `parity_en` is 1. Bit value = XOR of the data bits, inverted when `parity_odd` is set.
  - STOP: `tx`=1 for 1 or 2 bit periods.
- End of STOP: if the FIFO is non-empty, pop and go straight to START with no idle cycle. Otherwise go to IDLE and pulse `done_irq`.
- Baud counter: loaded with the latched divisor at every bit start and decremented each cycle. The bit advances when the counter is 0.
- Simultaneous pop and write: both take effect. `fifo_count` is unchanged.
- Reset: the FIFO is emptied and the FSM goes to IDLE. Output reset values: `tx`=1, `busy`=0, `done_irq`=0, `ovf`=0, `fifo_count`=0, `wr_ready`=1. Reset mid-frame aborts the frame, and `tx` returns high at the reset edge.

## Timing
- Outputs `tx`, `busy`, `done_irq`, `wr_ready`, `fifo_count` and `ovf` are all registered.
- Latency: a write accepted at edge E into an empty FIFO while IDLE is popped at edge E+1. From E+1, `tx`=0 and `busy`=1.
- Frame length: (1 + DATA_W + parity_en + 1 + two_stop) × (baud_div+1) cycles.
- `busy` stays high continuously across back-to-back frames.
- `done_irq` is asserted for exactly the one cycle following the final stop-bit cycle. `busy` falls on the same edge.
- `wr_ready` and `fifo_count` reflect a write or pop on the edge after it.
- A write is rejected whenever `wr_ready` is 0, even if a pop happens in the same cycle.

## Structure
- Package `uart_pkg`:
  - FSM state enum.
  - Parity-mode constants.
  - Function for the `fifo_count` width.
- Sub-module `uart_sync_fifo`, parametrised by width and depth:
  - Pointer-based storage with one extra wrap bit.
  - Signals: `push`, `pop`, `full`, `empty` and `count`.
- The top level holds the FSM, baud counter, shift register, bit counter, parity accumulator and flags.

## Test plan
- **Basic frame.** DATA_W=8, `baud_div`=3, no parity, 1 stop; write 0xA5.
  - `tx` = 0,1,0,1,0,0,1,0,1,1, each held 4 cycles.
  - `busy` high for 40 cycles; one `done_irq` pulse.
- **Parity.** Write 0xA5 (four ones) with `parity_en`=1.
  - `parity_odd`=0: parity bit is 0, frame is 44 cycles.
  - `parity_odd`=1: parity bit is 1.
  - Repeat with `two_stop`=1: frame is 48 cycles.
- **Back-to-back.** Write 0x01 and 0x80 on consecutive cycles.
  - No idle cycle between the frames; `busy` continuous for 80 cycles.
  - Exactly one `done_irq`, after the second frame.
- **Overflow.** `baud_div`=100; write 10 bytes on consecutive cycles.
  - One byte is popped immediately; `fifo_count` reaches 8 and `wr_ready` drops.
  - The 10th write is dropped and `ovf`=1; `ovf_clr` clears it.
  - The line later carries bytes 1 to 9 only, in order.
- **Reset mid-frame.** Assert `rst` during DATA of 0x55.
  - Next edge: `tx`=1, `busy`=0, `fifo_count`=0, no `done_irq`.
  - A subsequent write of 0x0F transmits correctly.
- **Small width, fast baud.** DATA_W=5, `baud_div`=0; write 5'h13.
  - `tx` = 0,1,1,0,0,1,1, one cycle per bit.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: shared FSM state type, parity-mode constants and FIFO count width helper
//   ST_*      : transmit FSM states
//   PAR_EVEN / PAR_ODD : parity_odd encodings
//   count_w() : width of an occupancy count for a power-of-two depth
package uart_pkg;
    typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP} tx_state_e;
    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;
    function automatic int count_w(input int depth);
        return $clog2(depth) + 1;
    endfunction
endpackage

// File: rtl/uart_sync_fifo.sv
// uart_sync_fifo: single-clock FIFO with wrap-bit pointers
//   clk, rst     : clock, synchronous active-high reset (empties the FIFO)
//   push, wdata  : write request and data (ignored when full)
//   pop, rdata   : read request (ignored when empty); rdata shows the head entry
//   full, empty  : occupancy flags
//   count        : occupied entries
module uart_sync_fifo
    import uart_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      push,
    input  logic                      pop,
    input  logic [WIDTH-1:0]          wdata,
    output logic [WIDTH-1:0]          rdata,
    output logic                      full,
    output logic                      empty,
    output logic [count_w(DEPTH)-1:0] count
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr, rd_ptr;
    // Extra MSB distinguishes full from empty when the index bits match.
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty = wr_ptr == rd_ptr;
    assign count = wr_ptr - rd_ptr;
    assign rdata = mem[rd_ptr[AW-1:0]];
    always_ff @(posedge clk) begin
        if (push && !full) mem[wr_ptr[AW-1:0]] <= wdata;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full) wr_ptr <= wr_ptr + 1'b1;
            if (pop && !empty) rd_ptr <= rd_ptr + 1'b1;
        end
    end
endmodule

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: FIFO-fed UART transmitter with programmable baud, width, parity and stop bits
//   clk, rst              : clock, synchronous active-high reset
//   baud_div              : bit period is baud_div+1 cycles
//   parity_en, parity_odd : parity enable and odd/even select
//   two_stop              : two stop bits when set
//   wr_data, wr_valid     : byte to queue and write request
//   wr_ready, fifo_count  : FIFO not full, occupied entries
//   ovf, ovf_clr          : sticky dropped-write flag and its clear
//   tx, busy, done_irq    : serial line, frame in progress, queue-drained pulse
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 8,
    parameter int DIV_W      = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [DIV_W-1:0]               baud_div,
    input  logic                           parity_en,
    input  logic                           parity_odd,
    input  logic                           two_stop,
    input  logic [DATA_W-1:0]              wr_data,
    input  logic                           wr_valid,
    output logic                           wr_ready,
    output logic [count_w(FIFO_DEPTH)-1:0] fifo_count,
    output logic                           ovf,
    input  logic                           ovf_clr,
    output logic                           tx,
    output logic                           busy,
    output logic                           done_irq
);
    localparam int BC_W = $clog2(DATA_W);
    tx_state_e         state;
    logic [DATA_W-1:0] shreg, head;
    logic [DIV_W-1:0]  baud_cnt, div_l;
    logic [BC_W-1:0]   bit_cnt;
    logic              par_en_l, two_l, par;
    logic              full, empty, push, pop, last_stop;
    assign push      = wr_valid && !full;
    assign wr_ready  = !full;
    assign last_stop = (state == ST_STOP) && (baud_cnt == '0) && (bit_cnt == '0);
    // Popping at the end of the last stop bit chains frames with no idle gap.
    assign pop       = !empty && ((state == ST_IDLE) || last_stop);
    uart_sync_fifo #(.WIDTH(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk  (clk),
        .rst  (rst),
        .push (push),
        .pop  (pop),
        .wdata(wr_data),
        .rdata(head),
        .full (full),
        .empty(empty),
        .count(fifo_count)
    );
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            tx       <= 1'b1;
            busy     <= 1'b0;
            done_irq <= 1'b0;
            ovf      <= 1'b0;
            shreg    <= '0;
            baud_cnt <= '0;
            div_l    <= '0;
            bit_cnt  <= '0;
            par_en_l <= 1'b0;
            two_l    <= 1'b0;
            par      <= 1'b0;
        end else begin
            done_irq <= 1'b0;
            // A new overflow wins over a simultaneous clear.
            if (wr_valid && !wr_ready) ovf <= 1'b1;
            else if (ovf_clr) ovf <= 1'b0;
            if (pop) begin
                state    <= ST_START;
                tx       <= 1'b0;
                busy     <= 1'b1;
                shreg    <= head;
                baud_cnt <= baud_div;
                div_l    <= baud_div;
                par_en_l <= parity_en;
                two_l    <= two_stop;
                // Seeding with the odd flag makes the running XOR yield odd parity directly.
                par      <= parity_odd == PAR_ODD;
            end else if (state != ST_IDLE) begin
                if (baud_cnt != '0) begin
                    baud_cnt <= baud_cnt - 1'b1;
                end else begin
                    baud_cnt <= div_l;
                    case (state)
                        ST_START: begin
                            state   <= ST_DATA;
                            tx      <= shreg[0];
                            par     <= par ^ shreg[0];
                            shreg   <= shreg >> 1;
                            bit_cnt <= BC_W'(DATA_W - 1);
                        end
                        ST_DATA: begin
                            if (bit_cnt != '0) begin
                                tx      <= shreg[0];
                                par     <= par ^ shreg[0];
                                shreg   <= shreg >> 1;
                                bit_cnt <= bit_cnt - 1'b1;
                            end else begin
                                state   <= par_en_l ? ST_PARITY : ST_STOP;
                                tx      <= par_en_l ? par : 1'b1;
                                bit_cnt <= BC_W'(two_l);
                            end
                        end
                        ST_PARITY: begin
                            state   <= ST_STOP;
                            tx      <= 1'b1;
                            bit_cnt <= BC_W'(two_l);
                        end
                        ST_STOP: begin
                            if (bit_cnt != '0) begin
                                bit_cnt <= bit_cnt - 1'b1;
                            end else begin
                                state    <= ST_IDLE;
                                busy     <= 1'b0;
                                done_irq <= 1'b1;
                            end
                        end
                        default: state <= ST_IDLE;
                    endcase
                end
            end
        end
    end
endmodule
